// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator sharing one period counter.
// Edge- or centre-aligned counting, per-channel polarity, and a shadow copy of
// the configuration that is only applied at a period boundary. A running
// period therefore always finishes with the settings it started with.
module pwm_multi_ch #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_load,
    input  logic [WIDTH-1:0]     cycle_in,
    input  logic [NCH*WIDTH-1:0] duty_in,
    input  logic                 center_in,
    input  logic [NCH-1:0]       pol_in,
    output logic [NCH-1:0]       pwm_out,
    output logic                 period_tick,
    output logic                 cfg_pending
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Counter state; dir = 1 while counting down (centre mode only)
    logic [WIDTH-1:0]     cnt;
    logic                 dir;

    // Active configuration driving the outputs
    logic [WIDTH-1:0]     c_act;
    logic [NCH*WIDTH-1:0] duty_act;
    logic                 center_act;
    logic [NCH-1:0]       pol_act;

    // Shadow configuration waiting for the next boundary
    logic [WIDTH-1:0]     c_sh;
    logic [NCH*WIDTH-1:0] duty_sh;
    logic                 center_sh;
    logic [NCH-1:0]       pol_sh;

    logic                 boundary;
    logic                 apply;
    logic [NCH-1:0]       raw;

    // Boundary = last count of the current period (its successor is cnt=0)
    always_comb begin
        boundary = 1'b0;
        if (c_act == '0)
            boundary = 1'b1;
        else if (!center_act)
            boundary = (cnt == c_act);
        else
            boundary = (cnt == ONE) && (dir || (c_act == ONE));
    end

    // While disabled the counter is parked at 0, so a pending shadow can
    // take effect right away instead of waiting for a boundary that never comes.
    assign apply = cfg_pending && (boundary || !en);

    // Per-channel compare of the shared counter against that channel's duty
    for (genvar i = 0; i < NCH; i++) begin : g_cmp
        assign raw[i] = (cnt < duty_act[i*WIDTH +: WIDTH]);
    end

    // Period counter: up for edge mode, up/down triangle for centre mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            dir <= 1'b0;
        end else if (!en || boundary) begin
            cnt <= '0;
            dir <= 1'b0;
        end else if (!center_act) begin
            cnt <= cnt + ONE;
        end else if (!dir) begin
            if (cnt == c_act) begin
                dir <= 1'b1;
                cnt <= cnt - ONE;
            end else begin
                cnt <= cnt + ONE;
            end
        end else begin
            cnt <= cnt - ONE;
        end
    end

    // Shadow capture and boundary-synchronous transfer to the active set.
    // A load coinciding with an apply moves the older shadow into service and
    // keeps the new values pending for the following boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_act       <= '0;
            duty_act    <= '0;
            center_act  <= 1'b0;
            pol_act     <= '0;
            c_sh        <= '0;
            duty_sh     <= '0;
            center_sh   <= 1'b0;
            pol_sh      <= '0;
            cfg_pending <= 1'b0;
        end else begin
            if (apply) begin
                c_act      <= c_sh;
                duty_act   <= duty_sh;
                center_act <= center_sh;
                pol_act    <= pol_sh;
            end
            if (cfg_load) begin
                c_sh      <= cycle_in;
                duty_sh   <= duty_in;
                center_sh <= center_in;
                pol_sh    <= pol_in;
            end
            if (cfg_load)
                cfg_pending <= 1'b1;
            else if (apply)
                cfg_pending <= 1'b0;
        end
    end

    // Registered outputs: one cycle behind the counter; idle level when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else if (en) begin
            pwm_out     <= raw ^ pol_act;
            period_tick <= boundary;
        end else begin
            pwm_out     <= pol_act;
            period_tick <= 1'b0;
        end
    end

endmodule
